// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: sample width, clamp limits and sample type.
package fir_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 16'h8000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_sat_minus.sv
// Combinational saturating signed subtractor: result = sat(a - b).
module fir_sat_minus
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  logic [WIDTH:0] r;

  always_comb begin
    r = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    sat = (r[WIDTH] != r[WIDTH-1]);
    if (sat) begin
      // Overflow can only occur when a and b have opposite signs, so a's sign picks the rail.
      result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = r[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_saturating_comb.sv
// Saturating comb stage y[n] = sat(x[n] - x[n-D]) with valid/ready on both sides
// and a sticky saturation-event counter.
module fir_saturating_comb
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH     = SAMPLE_W,
  parameter int unsigned DELAY     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] sat_count
);

  logic [WIDTH-1:0] dly [DELAY];
  logic [WIDTH-1:0] diff;
  logic             diff_sat;
  logic             acc_in;
  logic             xfer_out;

  assign in_ready = !out_valid || out_ready;
  assign acc_in   = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  fir_sat_minus #(
    .WIDTH (WIDTH)
  ) u_sat_minus (
    .a      (in_data),
    .b      (dly[DELAY-1]),
    .result (diff),
    .sat    (diff_sat)
  );

  // The line shifts only on accepted samples, so D counts samples rather than cycles.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        dly[i] <= '0;
      end
    end else if (acc_in) begin
      dly[0] <= in_data;
      for (int unsigned i = 1; i < DELAY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (acc_in) begin
      out_valid <= 1'b1;
      out_data  <= diff;
      out_sat   <= diff_sat;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      sat_count <= '0;
    end else if (xfer_out && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_saturating_comb.sv
// Scoreboard bench for fir_saturating_comb: a sample-indexed golden model pushes
// expected results on accept; a monitor pops and compares them on each transfer.
module tb_fir_saturating_comb;

  localparam int W    = 16;
  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_sat;
  logic [CW-1:0] sat_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb [$];
  int   hist [$];
  int   exp_cnt = 0;
  logic have_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic prev_sat;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  fir_saturating_comb #(
    .WIDTH     (W),
    .DELAY     (D),
    .CNT_WIDTH (CW)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sat        (out_sat),
    .sat_count      (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int r;
    r = a - b;
    if (r > 32767) begin
      e.d = 16'h7FFF; e.s = 1'b1;
    end else if (r < -32768) begin
      e.d = 16'h8000; e.s = 1'b1;
    end else begin
      e.d = r[W-1:0]; e.s = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   a, b;
    if (rst) begin
      sb.delete();
      hist.delete();
      exp_cnt   = 0;
      have_prev = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      check("pending", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      check("sat_count", {29'd0, sat_count}, exp_cnt);
      if (have_prev) begin
        check("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        check("stall_sat", {31'd0, out_sat}, {31'd0, prev_sat});
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e.d});
        check("out_sat", {31'd0, out_sat}, {31'd0, e.s});
        if (e.s && exp_cnt < CMAX) exp_cnt++;
      end
      if (in_valid && in_ready) begin
        a = int'($signed(in_data));
        b = (hist.size() >= D) ? hist[hist.size() - D] : 0;
        sb.push_back(model(a, b));
        hist.push_back(a);
      end
      have_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_sat  = out_sat;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int v);
    int   n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    in_data  = v[W-1:0];
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    check("rst_count", {29'd0, sat_count}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1 [6] = '{100, 200, 300, 400, 500, 600};
    int t2 [5] = '{-32768, 0, 0, 0, 32767};
    int t3 [10] = '{32767, 0, 0, 0, -2, 0, 0, 0, 1, -32768};
    @(posedge clk);
    #1;
    do_reset();

    foreach (t1[i]) send(t1[i]);
    idle(3);

    do_reset();
    foreach (t2[i]) send(t2[i]);
    idle(3);
    check("t2_count", {29'd0, sat_count}, 32'd1);

    do_reset();
    foreach (t3[i]) send(t3[i]);
    idle(3);

    out_ready = 1'b0;
    fork
      begin
        send(1000); send(-1000); send(20000); send(-20000); send(7);
      end
      begin
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(3);

    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b0;
      idle($urandom_range(0, 3));
      send(int'($signed(16'($urandom))));
    end
    rand_rdy = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(3);

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < D; j++) send(-32768);
      for (int j = 0; j < D; j++) send(32767);
    end
    idle(3);
    check("cnt_sticky", {29'd0, sat_count}, CMAX);

    out_ready = 1'b0;
    send(77);
    do_reset();
    out_ready = 1'b1;
    send(50);
    idle(3);

    check("drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_saturating_comb.md
Name: fir_saturating_comb

Overview:
Saturating signed comb (differentiator) stage for the FIR datapath: y[n] = sat(x[n] - x[n-D]).
- The subtracting counterpart of the saturating adder: it undoes an integrator/accumulator at the opposite end of the sample chain.
- Sits between a sample source and a downstream FIR or decimator.
- Uses valid/ready handshakes on both sides, a D-deep sample delay line, one output register stage, and a saturation-event counter.

Parameters:
WIDTH, 16, sample width in bits (signed, two's complement)
DELAY, 4, comb delay D in accepted samples; legal range 1..64
CNT_WIDTH, 16, width of the saturation event counter

Ports:
system1000  input  1  clock; all state updates on the rising edge
system1000_rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  WIDTH  signed sample x[n]
out_valid  output  1  out_data holds a valid result
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  signed saturated difference y[n]
out_sat  output  1  out_data was clamped; qualified by out_valid
sat_count  output  CNT_WIDTH  number of saturated results delivered; sticks at all-ones

Behaviour:
Interface decision: one clock (system1000); reset system1000_rst is synchronous and active-high.

Reset (sampled high at a rising edge):
- out_valid=0, out_data=0, out_sat=0, sat_count=0.
- All DELAY delay-line entries = 0.
- Reset overrides any handshake in the same cycle. A mid-stream reset drops the pending output and the delay-line history.

Handshake:
- Input accept: acc_in = in_valid & in_ready.
- in_ready = !out_valid | out_ready. Combinational from out_ready; there is no path from in_valid to in_ready.
- Output transfer: out_valid & out_ready.
- out_data and out_sat stay stable while out_valid=1 and out_ready=0.
- out_valid clears after a transfer cycle with no new accept.
- Transfer and accept in the same cycle: the register reloads and out_valid stays 1.

Latency and throughput:
- Accepted sample appears on out_data in the next cycle (1-cycle latency).
- Full throughput of 1 sample/cycle while out_ready=1.

Delay line:
- Shift register of DELAY entries; it advances only on acc_in.
- Tap b = entry holding x[n-D]. In the accept cycle, in_data enters the head and the oldest entry is discarded.
- Stalls (in_valid=0 or in_ready=0) freeze the line, so D counts accepted samples, not cycles.

Arithmetic:
- a = in_data, b = tap. r = sign-extend(a) - sign-extend(b) at WIDTH+1 bits.
- Overflow when r[WIDTH] != r[WIDTH-1].
- On overflow: result = 2^(WIDTH-1)-1 if a's MSB=0, else -2^(WIDTH-1); out_sat=1.
- Otherwise: result = r[WIDTH-1:0]; out_sat=0.

Counter:
- sat_count increments by 1 on each output transfer with out_sat=1.
- It holds at 2^CNT_WIDTH-1 and does not wrap.

Start-up:
- For the first DELAY accepted samples after reset, b=0, so y=x (never saturates).

Decomposition:
- Shared package fir_pkg: sample width constant (16), SAMPLE_MAX (0x7FFF), SAMPLE_MIN (0x8000), signed sample typedef.
- One combinational sub-module, fir_sat_minus (a, b -> result, sat), instantiated once. Its saturation rule is as above.
- Delay line, handshake, output register and counter are in the top level.

Test Plan:
1. Reset, then stream 100, 200, 300, 400, 500, 600 with out_ready=1 -> outputs 100, 200, 300, 400, 400, 400 (sample 5 = 500-100, sample 6 = 600-200); each output 1 cycle after accept; out_sat=0; sat_count=0.
2. Stream -32768, 0, 0, 0, 32767 -> 5th output 0x7FFF, out_sat=1, sat_count=1.
3. Stream 32767, 0, 0, 0, -2 -> 5th output 0x8000 (-32769 clamped), out_sat=1.
   Then 0, 0, 0, 1, -32768 -> last output -32768 (-32768-0, exact), out_sat=0.
4. Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 after first accept; out_data stable; delay line frozen.
   Release -> results identical to an unstalled run of the same samples.
5. Toggle in_valid randomly for 10 samples with gaps -> outputs match the golden model indexed by accepted samples, not cycles.
6. Assert system1000_rst for 1 cycle with out_valid=1 mid-stream -> next cycle out_valid=0 and sat_count=0.
   Next input 50 -> output 50 (history cleared).
